// File: rtl/y86_writeback_regfile_if.sv
// Write-back bus, decode read ports and architectural status between the SEQ core and the register file.
interface y86_writeback_regfile_if #(
   parameter int unsigned NREG  = 15,
   parameter int unsigned CNT_W = 32
) ();
   localparam int unsigned FLAT_W = NREG * 64;

   logic              wb_valid;
   logic [3:0]        icode;
   logic              cnd;
   logic [3:0]        rA;
   logic [3:0]        rB;
   logic [63:0]       valE;
   logic [63:0]       valM;
   logic [1:0]        stat;
   logic [3:0]        srcA;
   logic [3:0]        srcB;
   logic [63:0]       valA;
   logic [63:0]       valB;
   logic [FLAT_W-1:0] regs_flat;
   logic              halted;
   logic [1:0]        stat_out;
   logic [CNT_W-1:0]  retired;

   // Core side: presents completing instructions and read addresses.
   modport master (
      output wb_valid, icode, cnd, rA, rB, valE, valM, stat, srcA, srcB,
      input  valA, valB, regs_flat, halted, stat_out, retired
   );

   // Register-file side.
   modport slave (
      input  wb_valid, icode, cnd, rA, rB, valE, valM, stat, srcA, srcB,
      output valA, valB, regs_flat, halted, stat_out, retired
   );
endinterface

// File: rtl/y86_writeback_regfile.sv
// Y86-64 SEQ write-back stage: destination decode, register file, halt state and retire counter.
module y86_writeback_regfile #(
   parameter int unsigned NREG  = 15,
   parameter int unsigned CNT_W = 32
) (
   input logic                      clk,
   input logic                      rst_n,
   y86_writeback_regfile_if.slave   wb
);
   localparam logic [3:0] REG_NONE = 4'hF;
   localparam logic [3:0] REG_RSP  = 4'h4;
   localparam logic [3:0] I_CMOVXX = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [1:0] STAT_AOK = 2'd0;

   typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [1:0]       stat_q, stat_d;
   logic             commit_c;
   logic [3:0]       dst_e_c, dst_m_c;
   logic [63:0]      regs_q [NREG];
   logic [CNT_W-1:0] retired_q;

   // Destination register decode from the completing instruction.
   always_comb begin
      dst_e_c = REG_NONE;
      dst_m_c = REG_NONE;
      case (wb.icode)
         I_CMOVXX:                       dst_e_c = wb.cnd ? wb.rB : REG_NONE;
         I_IRMOVQ, I_OPQ:                dst_e_c = wb.rB;
         I_CALL, I_RET, I_PUSHQ, I_POPQ: dst_e_c = REG_RSP;
         default:                        dst_e_c = REG_NONE;
      endcase
      case (wb.icode)
         I_MRMOVQ, I_POPQ: dst_m_c = wb.rA;
         default:          dst_m_c = REG_NONE;
      endcase
   end

   // Halt FSM next state; a non-AOK completion halts instead of committing.
   always_comb begin
      state_d  = state_q;
      stat_d   = stat_q;
      commit_c = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (wb.wb_valid) begin
               if (wb.stat == STAT_AOK) begin
                  commit_c = 1'b1;
               end else begin
                  state_d = ST_HALTED;
                  stat_d  = wb.stat;
               end
            end
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_RUN;
      endcase
   end

   // Halt state and latched status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         stat_q  <= STAT_AOK;
      end else begin
         state_q <= state_d;
         stat_q  <= stat_d;
      end
   end

   // Register file; the valM write is issued last so it wins a dstE==dstM collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (commit_c) begin
         if (dst_e_c != REG_NONE) regs_q[dst_e_c] <= wb.valE;
         if (dst_m_c != REG_NONE) regs_q[dst_m_c] <= wb.valM;
      end
   end

   // Saturating retired-instruction counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_q <= '0;
      end else if (commit_c && (retired_q != '1)) begin
         retired_q <= retired_q + CNT_W'(1);
      end
   end

   // Read ports (no bypass), snapshot and status outputs.
   always_comb begin
      wb.valA      = (wb.srcA == REG_NONE) ? 64'd0 : regs_q[wb.srcA];
      wb.valB      = (wb.srcB == REG_NONE) ? 64'd0 : regs_q[wb.srcB];
      wb.regs_flat = '0;
      for (int i = 0; i < NREG; i++) wb.regs_flat[64*i +: 64] = regs_q[i];
      wb.halted    = (state_q == ST_HALTED);
      wb.stat_out  = stat_q;
      wb.retired   = retired_q;
   end
endmodule

// File: tb/tb_y86_writeback_regfile.sv
// Directed bench for y86_writeback_regfile with an architectural reference model.
module tb_y86_writeback_regfile;
   localparam int unsigned NREG  = 15;
   localparam int unsigned CNT_W = 32;

   logic clk;
   logic rst_n;
   y86_writeback_regfile_if #(.NREG(NREG), .CNT_W(CNT_W)) wbif ();

   y86_writeback_regfile #(.NREG(NREG), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (wbif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Literal expectations: sel 0 valA, 1 valB, 2 halted, 3 stat_out, 4 retired, 5 regs_flat all zero, 16+i register i.
   typedef struct {
      string       name;
      int          sel;
      logic [63:0] val;
   } exp_t;

   exp_t        eq[$];
   event        chk_ev;
   bit          chk_en;
   int          checks;
   int          errors;

   // Architectural model state.
   logic [63:0]      m_reg [NREG];
   logic             m_halt;
   logic [1:0]       m_stat;
   logic [CNT_W-1:0] m_ret;

   function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic c);
      case (ic)
         4'h2:                   return c ? rb : 4'hF;
         4'h3, 4'h6:             return rb;
         4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
         default:                return 4'hF;
      endcase
   endfunction

   function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
      return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
   endfunction

   function automatic logic [63:0] m_rd(input logic [3:0] s);
      return (s == 4'hF) ? 64'd0 : m_reg[s];
   endfunction

   function automatic logic [NREG*64-1:0] m_flat();
      logic [NREG*64-1:0] f;
      f = '0;
      for (int i = 0; i < NREG; i++) f[64*i +: 64] = m_reg[i];
      return f;
   endfunction

   // Reference model: commits AOK completions while running, halts on any other status.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) m_reg[i] <= '0;
         m_halt <= 1'b0;
         m_stat <= 2'd0;
         m_ret  <= '0;
      end else if (!m_halt && wbif.wb_valid) begin
         if (wbif.stat != 2'd0) begin
            m_halt <= 1'b1;
            m_stat <= wbif.stat;
         end else begin
            if (m_dst_e(wbif.icode, wbif.rB, wbif.cnd) != 4'hF)
               m_reg[m_dst_e(wbif.icode, wbif.rB, wbif.cnd)] <= wbif.valE;
            if (m_dst_m(wbif.icode, wbif.rA) != 4'hF)
               m_reg[m_dst_m(wbif.icode, wbif.rA)] <= wbif.valM;
            if (m_ret != '1) m_ret <= m_ret + CNT_W'(1);
         end
      end
   end

   task automatic check(input string nm, input logic [NREG*64-1:0] act, input logic [NREG*64-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Compare process: model against DUT every falling edge, plus queued literal expectations.
   always begin
      @(negedge clk or chk_ev);
      if (chk_en) begin
         check("model_halted",   (NREG*64)'(wbif.halted),   (NREG*64)'(m_halt));
         check("model_stat_out", (NREG*64)'(wbif.stat_out), (NREG*64)'(m_stat));
         check("model_retired",  (NREG*64)'(wbif.retired),  (NREG*64)'(m_ret));
         check("model_regs",     wbif.regs_flat,            m_flat());
         check("model_valA",     (NREG*64)'(wbif.valA),     (NREG*64)'(m_rd(wbif.srcA)));
         check("model_valB",     (NREG*64)'(wbif.valB),     (NREG*64)'(m_rd(wbif.srcB)));
         while (eq.size() > 0) begin
            exp_t e;
            logic [NREG*64-1:0] act;
            e = eq.pop_front();
            case (e.sel)
               0:       act = (NREG*64)'(wbif.valA);
               1:       act = (NREG*64)'(wbif.valB);
               2:       act = (NREG*64)'(wbif.halted);
               3:       act = (NREG*64)'(wbif.stat_out);
               4:       act = (NREG*64)'(wbif.retired);
               5:       act = wbif.regs_flat;
               default: act = (NREG*64)'(wbif.regs_flat[64*(e.sel-16) +: 64]);
            endcase
            check(e.name, act, (NREG*64)'(e.val));
         end
      end
   end

   task automatic want(input string nm, input int sel, input logic [63:0] v);
      exp_t e;
      e.name = nm;
      e.sel  = sel;
      e.val  = v;
      eq.push_back(e);
   endtask

   task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic c, input logic [63:0] ve, input logic [63:0] vm, input logic [1:0] st);
      wbif.wb_valid = 1'b1;
      wbif.icode    = ic;
      wbif.rA       = ra;
      wbif.rB       = rb;
      wbif.cnd      = c;
      wbif.valE     = ve;
      wbif.valM     = vm;
      wbif.stat     = st;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      wbif.wb_valid = 1'b0;
      wbif.icode = 4'h0; wbif.rA = 4'hF; wbif.rB = 4'hF; wbif.cnd = 1'b0;
      wbif.valE = '0; wbif.valM = '0; wbif.stat = 2'd0;
      wbif.srcA = 4'h3; wbif.srcB = 4'h2;
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      chk_en = 1'b1;
      want("reset_regs", 5, 64'd0);
      want("reset_halted", 2, 64'd0);
      want("reset_retired", 4, 64'd0);
      want("reset_stat_out", 3, 64'd0);

      drive(4'h3, 4'hF, 4'h3, 1'b0, 64'h1234, 64'h0, 2'd0); step();
      want("irmovq_r3", 16+3, 64'h1234);
      want("irmovq_valA", 0, 64'h1234);
      want("irmovq_retired", 4, 64'd1);

      drive(4'h6, 4'hF, 4'hF, 1'b0, 64'h999, 64'h0, 2'd0); step();
      want("opq_f_r3", 16+3, 64'h1234);
      want("opq_f_retired", 4, 64'd2);

      drive(4'h2, 4'hF, 4'h2, 1'b0, 64'hAA, 64'h0, 2'd0); step();
      want("cmov_nc_r2", 16+2, 64'd0);
      want("cmov_nc_retired", 4, 64'd3);

      drive(4'h2, 4'hF, 4'h2, 1'b1, 64'hAA, 64'h0, 2'd0); step();
      want("cmov_c_r2", 16+2, 64'hAA);
      want("cmov_c_valB", 1, 64'hAA);

      drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hBEEF, 2'd0); step();
      want("popq_rsp_r4", 16+4, 64'hBEEF);

      drive(4'hB, 4'h1, 4'hF, 1'b0, 64'h108, 64'hBEEF, 2'd0); step();
      want("popq_r1", 16+1, 64'hBEEF);
      want("popq_r1_r4", 16+4, 64'h108);
      want("popq_retired", 4, 64'd6);

      drive(4'h5, 4'h7, 4'h2, 1'b0, 64'h10, 64'h5555, 2'd0); step();
      want("mrmovq_r7", 16+7, 64'h5555);
      want("mrmovq_r2", 16+2, 64'hAA);

      drive(4'h8, 4'hF, 4'hF, 1'b0, 64'h200, 64'h0, 2'd0); step();
      want("call_r4", 16+4, 64'h200);

      // Bypass: read of R3 shows the pre-edge value while its write is pending.
      @(negedge clk);
      #1;
      wbif.srcB = 4'h3;
      drive(4'h3, 4'hF, 4'h3, 1'b0, 64'h77, 64'h0, 2'd0);
      want("bypass_pre_valB", 1, 64'h1234);
      -> chk_ev;
      step();
      want("bypass_post_valB", 1, 64'h77);
      wbif.wb_valid = 1'b0;
      wbif.srcA = 4'hF;
      step();
      want("read_f_valA", 0, 64'd0);
      want("idle_retired", 4, 64'd9);

      drive(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 2'd1); step();
      want("halt_halted", 2, 64'd1);
      want("halt_stat_out", 3, 64'd1);
      want("halt_retired", 4, 64'd9);

      drive(4'h3, 4'hF, 4'h5, 1'b0, 64'h55, 64'h0, 2'd0); step();
      want("halted_r5", 16+5, 64'd0);
      want("halted_retired", 4, 64'd9);

      drive(4'h3, 4'hF, 4'h5, 1'b0, 64'h55, 64'h0, 2'd2); step();
      want("halted_stat_kept", 3, 64'd1);

      // Asynchronous reset pulse mid-cycle with a write pending.
      @(negedge clk);
      #1;
      drive(4'h3, 4'hF, 4'h6, 1'b0, 64'h66, 64'h0, 2'd0);
      rst_n = 1'b0;
      #1;
      want("async_rst_regs", 5, 64'd0);
      want("async_rst_halted", 2, 64'd0);
      want("async_rst_stat_out", 3, 64'd0);
      want("async_rst_retired", 4, 64'd0);
      -> chk_ev;
      step();
      want("rst_wins_r6", 16+6, 64'd0);
      want("rst_wins_retired", 4, 64'd0);
      rst_n = 1'b1;
      step();
      want("after_rst_r6", 16+6, 64'h66);
      want("after_rst_retired", 4, 64'd1);

      drive(4'h3, 4'hF, 4'hE, 1'b0, 64'hE, 64'h0, 2'd0); step();
      want("r14_write", 16+14, 64'hE);
      want("r14_retired", 4, 64'd2);
      wbif.wb_valid = 1'b0;
      step();
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
